// File: rtl/if_stage_if.sv
// Bus bundle between the instruction-fetch stage and its environment:
// ID-stage control (stall / redirect), instruction memory, and the IF/ID register.
//
// Handshake semantics: id_valid qualifies id_instr and id_pc4 in every cycle.
// When id_valid=0 the word on id_instr is a bubble (NOP_INSTR) and id_pc4 is 0.
// The consumer has no ready signal. It holds the stage with stall, and a
// redirect always wins over stall. im_addr is always a live request, and
// im_instr must answer it combinationally in the same cycle.
interface if_stage_if;
    logic        stall;
    logic        redirect;
    logic [1:0]  redirect_kind;
    logic [31:0] redirect_pc4;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] jr_addr;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;

    // Environment side: ID control plus instruction memory response.
    modport master (
        output stall, redirect, redirect_kind, redirect_pc4, imm16, target26, jr_addr,
        output im_instr,
        input  im_addr, id_instr, id_pc4, id_valid
    );

    // Fetch stage side.
    modport slave (
        input  stall, redirect, redirect_kind, redirect_pc4, imm16, target26, jr_addr,
        input  im_instr,
        output im_addr, id_instr, id_pc4, id_valid
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register. Redirect beats stall, and stall beats sequential fetch.
// Every redirect inserts exactly one bubble into ID.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    rst_n,
    if_stage_if.slave bus
);

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JUMP   = 2'b01;
    localparam logic [1:0] KIND_JR     = 2'b10;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] redirect_target;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc4_q;
    logic        id_valid_q;

    // The fetch address comes straight from the PC flop, with no input-to-output path.
    assign bus.im_addr  = pc;
    assign bus.id_instr = id_instr_q;
    assign bus.id_pc4   = id_pc4_q;
    assign bus.id_valid = id_valid_q;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

    // Select the redirect target by kind. The reserved kind falls through to PC+4.
    always_comb begin
        redirect_target = bus.redirect_pc4;
        case (bus.redirect_kind)
            KIND_BRANCH: redirect_target = bus.redirect_pc4 + branch_off;
            KIND_JUMP:   redirect_target = {bus.redirect_pc4[31:28], bus.target26, 2'b00};
            KIND_JR:     redirect_target = bus.jr_addr & 32'hFFFF_FFFC;
            default:     redirect_target = bus.redirect_pc4;
        endcase
    end

    // PC register: redirect, then stall (hold), then sequential advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (bus.redirect) begin
            pc <= redirect_target;
        end else if (!bus.stall) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID register: a redirect flushes to a bubble, a stall holds, otherwise the fetched word is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr_q <= NOP_INSTR;
            id_pc4_q   <= 32'h0;
            id_valid_q <= 1'b0;
        end else if (bus.redirect) begin
            id_instr_q <= NOP_INSTR;
            id_pc4_q   <= 32'h0;
            id_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            id_instr_q <= bus.im_instr;
            id_pc4_q   <= pc_plus4;
            id_valid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. The driver pushes the expected
// {im_addr, id_instr, id_pc4, id_valid} for each sample point into exp_q.
// The monitor pops one entry and compares it each time a sample is signalled.
module tb_if_stage;

    localparam int W = 97;

    logic clk;
    logic rst_n;
    logic use_const;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory model: either a constant word or a word tagged with its address.
    assign bus.im_instr = use_const ? 32'h0000_1820 : (32'hC0DE_0000 | bus.im_addr);

    int          tests_run;
    int          tests_failed;
    logic [W-1:0] exp_q[$];
    event        sample_ev;

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic set_idle();
        bus.stall         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_kind = 2'b00;
        bus.redirect_pc4  = 32'h0;
        bus.imm16         = 16'h0;
        bus.target26      = 26'h0;
        bus.jr_addr       = 32'h0;
    endtask

    // Wait for one clock edge, then sample against exp.
    task automatic step(input logic [31:0] a, input logic [31:0] ins,
                        input logic [31:0] p4, input logic v);
        exp_q.push_back({a, ins, p4, v});
        @(posedge clk);
        #1;
        -> sample_ev;
        #1;
    endtask

    // Sample right now, between edges.
    task automatic check_now(input logic [31:0] a, input logic [31:0] ins,
                             input logic [31:0] p4, input logic v);
        exp_q.push_back({a, ins, p4, v});
        -> sample_ev;
        #1;
    endtask

    task automatic do_redirect(input logic [1:0] kind, input logic [31:0] pc4,
                               input logic [15:0] imm, input logic [25:0] t26,
                               input logic [31:0] jr, input logic stl);
        bus.redirect      = 1'b1;
        bus.redirect_kind = kind;
        bus.redirect_pc4  = pc4;
        bus.imm16         = imm;
        bus.target26      = t26;
        bus.jr_addr       = jr;
        bus.stall         = stl;
    endtask

    // Scoreboard monitor.
    initial begin
        logic [W-1:0] exp;
        logic [W-1:0] act;
        forever begin
            @(sample_ev);
            act = {bus.im_addr, bus.id_instr, bus.id_pc4, bus.id_valid};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sample_%0d: got sample with empty queue, required an expected entry", tests_run);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    tests_failed++;
                    $display("FAIL sample_%0d: got im_addr=%h id_instr=%h id_pc4=%h id_valid=%b, required im_addr=%h id_instr=%h id_pc4=%h id_valid=%b",
                             tests_run, act[96:65], act[64:33], act[32:1], act[0],
                             exp[96:65], exp[64:33], exp[32:1], exp[0]);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        use_const    = 1'b1;
        set_idle();
        rst_n = 1'b0;
        #2;
        check_now(32'h0, 32'h0, 32'h0, 1'b0);          // immediate async reset values
        step(32'h0, 32'h0, 32'h0, 1'b0);               // holds while in reset
        @(negedge clk);
        rst_n = 1'b1;

        // Free run with a constant instruction word.
        step(32'h4, 32'h0000_1820, 32'h4, 1'b1);
        step(32'h8, 32'h0000_1820, 32'h8, 1'b1);
        step(32'hC, 32'h0000_1820, 32'hC, 1'b1);

        // Switch to address-tagged words, rewind to 0x4, fetch up to PC=0x8, then stall.
        use_const = 1'b0;
        do_redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'h4, 1'b0);
        step(32'h4, 32'h0, 32'h0, 1'b0);
        set_idle();
        step(32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
        bus.stall = 1'b1;
        step(32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
        step(32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
        bus.stall = 1'b0;
        step(32'hC, 32'hC0DE_0008, 32'hC, 1'b1);

        // Branches forward and backward, one bubble each.
        do_redirect(2'b00, 32'h1C, 16'h0002, 26'h0, 32'h0, 1'b0);
        step(32'h24, 32'h0, 32'h0, 1'b0);
        set_idle();
        step(32'h28, 32'hC0DE_0024, 32'h28, 1'b1);
        do_redirect(2'b00, 32'h1C, 16'hFFFE, 26'h0, 32'h0, 1'b0);
        step(32'h14, 32'h0, 32'h0, 1'b0);
        set_idle();
        step(32'h18, 32'hC0DE_0014, 32'h18, 1'b1);

        // Jump, then back-to-back jump-register with the low address bits dropped.
        do_redirect(2'b01, 32'h5C, 16'h0, 26'h1A, 32'h0, 1'b0);
        step(32'h68, 32'h0, 32'h0, 1'b0);
        do_redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'h5B, 1'b0);
        step(32'h58, 32'h0, 32'h0, 1'b0);
        set_idle();
        step(32'h5C, 32'hC0DE_0058, 32'h5C, 1'b1);

        // Reserved kind behaves as a redirect to redirect_pc4.
        do_redirect(2'b11, 32'h100, 16'h0040, 26'h3FF, 32'h80, 1'b0);
        step(32'h100, 32'h0, 32'h0, 1'b0);

        // Redirect together with stall: the redirect wins. Then the stall alone holds the bubble.
        do_redirect(2'b00, 32'h10, 16'h0001, 26'h0, 32'h0, 1'b1);
        step(32'h14, 32'h0, 32'h0, 1'b0);
        bus.redirect = 1'b0;
        step(32'h14, 32'h0, 32'h0, 1'b0);
        set_idle();
        step(32'h18, 32'hC0DE_0014, 32'h18, 1'b1);

        // Jump keeps the upper nibble of redirect_pc4.
        do_redirect(2'b01, 32'hA000_0010, 16'h0, 26'h3FF_FFFF, 32'h0, 1'b0);
        step(32'hAFFF_FFFC, 32'h0, 32'h0, 1'b0);

        // Preload the top address through jr and wrap to 0.
        do_redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFF, 1'b0);
        step(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        set_idle();
        step(32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
        step(32'h4, 32'hC0DE_0000, 32'h4, 1'b1);

        // Reset during redirect and stall overrides both, including across an edge.
        do_redirect(2'b01, 32'h40, 16'h0, 26'h20, 32'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_now(32'h0, 32'h0, 32'h0, 1'b0);
        step(32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        set_idle();
        rst_n = 1'b1;
        step(32'h4, 32'hC0DE_0000, 32'h4, 1'b1);
        step(32'h8, 32'hC0DE_0004, 32'h8, 1'b1);

        // Short reset pulse between edges, then fetch from 0.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_now(32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        step(32'h4, 32'hC0DE_0000, 32'h4, 1'b1);

        #2;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0000, instruction word driven on id_instr for a bubble.
REQ-003 The block SHALL run on one clock, with asynchronous active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 stall  input  1  hold PC and the IF/ID register.
REQ-007 redirect  input  1  change of flow resolved in ID this cycle.
REQ-008 redirect_kind  input  2  00 branch, 01 jump, 10 jump-register, 11 reserved.
REQ-009 redirect_pc4  input  32  PC+4 of the redirecting instruction.
REQ-010 imm16  input  16  branch word offset.
REQ-011 target26  input  26  jump word index.
REQ-012 jr_addr  input  32  register target for jump-register.
REQ-013 im_addr  output  32  fetch byte address to instruction memory, equal to current PC.
REQ-014 im_instr  input  32  combinational instruction word returned for im_addr.
REQ-015 id_instr  output  32  registered instruction to decode.
REQ-016 id_pc4  output  32  registered PC+4 of id_instr.
REQ-017 id_valid  output  1  id_instr is a real fetched instruction.

Function
REQ-018 The PC SHALL be a 32-bit register, and im_addr SHALL be driven directly from it with no combinational path from any input.
REQ-019 Priority at each rising edge SHALL be: redirect first, then stall, then sequential.
REQ-020 Sequential (redirect=0, stall=0): PC <= PC+4, modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-021 Branch target SHALL be redirect_pc4 + {sign-extended imm16, 2'b00}, using 32-bit modulo arithmetic.
REQ-022 Jump target SHALL be {redirect_pc4[31:28], target26, 2'b00}.
REQ-023 Jump-register target SHALL be {jr_addr[31:2], 2'b00}, with the low bits forced to zero.
REQ-024 When redirect_kind=11, the block SHALL treat the redirect as a sequential redirect: PC <= redirect_pc4.
REQ-025 Redirect edge: PC <= target; id_instr <= NOP_INSTR; id_valid <= 0; id_pc4 <= 0. This applies even if stall=1.
REQ-026 Stall edge (redirect=0): PC, id_instr, id_pc4 and id_valid SHALL hold.
REQ-027 Sequential edge: id_instr <= im_instr; id_pc4 <= PC+4; id_valid <= 1.
REQ-028 im_instr SHALL be captured as presented, with no X-filtering; id_valid still follows REQ-027.
REQ-029 Latency: an instruction fetched at PC in cycle N SHALL appear on id_instr in cycle N+1; a redirect in cycle N SHALL make im_addr equal the target in cycle N+1.
REQ-030 Exactly one bubble SHALL follow each redirect; back-to-back redirects SHALL each retarget the PC and keep id_valid=0.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, set PC=RESET_PC (so im_addr=RESET_PC), id_instr=NOP_INSTR, id_pc4=0 and id_valid=0.
REQ-032 These values SHALL hold while rst_n=0.
REQ-033 The first rising edge with rst_n=1 SHALL perform a normal sequential fetch.
REQ-034 Reset asserted mid-stall or mid-redirect SHALL override both.

Verification
REQ-035 Reset, then 3 free-run edges with im_instr=32'h0000_1820 at every address -> im_addr sequence 0x0, 0x4, 0x8, 0xC; id_pc4 sequence 0x4, 0x8, 0xC; id_valid=1 from the first edge.
REQ-036 At PC=0x8, hold stall=1 for 2 edges -> im_addr stays 0x8, id_instr/id_pc4 unchanged; after release, im_addr=0xC.
REQ-037 Branch redirect_pc4=0x1C: imm16=0x0002 -> im_addr=0x24; imm16=0xFFFE -> im_addr=0x14; id_valid=0 and id_instr=NOP_INSTR for one cycle in each case.
REQ-038 Jump with redirect_pc4=0x5C, target26=0x1A -> im_addr=0x68; jump-register with jr_addr=0x5B -> im_addr=0x58.
REQ-039 redirect=1 and stall=1 on the same edge (branch, redirect_pc4=0x10, imm16=1) -> im_addr=0x14, id_valid=0; with PC preloaded to 0xFFFF_FFFC and a sequential edge -> im_addr=0x0.
REQ-040 rst_n pulsed low between edges mid-run -> im_addr=0x0 and id_valid=0 before the next edge; the following edge fetches from 0x0.
